// File: rtl/snn_pkg.sv
// Shared fixed-point formats, limits and state encoding for the spiking-neuron datapath.
package snn_pkg;

    localparam int SUM_W = 11;  // MAC sum, signed Q4.7
    localparam int FRAC  = 7;
    localparam int V_W   = 16;  // membrane potential, signed Q8.7

    typedef logic signed [SUM_W-1:0] sum_t;
    typedef logic signed [V_W-1:0]   v_t;
    typedef logic signed [V_W+1:0]   v_ext_t;

    localparam v_t V_MAX = {1'b0, {(V_W-1){1'b1}}};
    localparam v_t V_MIN = {1'b1, {(V_W-1){1'b0}}};

    localparam v_ext_t V_MAX_EXT = {3'b000, {(V_W-1){1'b1}}};
    localparam v_ext_t V_MIN_EXT = {3'b111, {(V_W-1){1'b0}}};

    localparam logic [0:0] INTEGRATE = 1'b0;
    localparam logic [0:0] REFRACT   = 1'b1;

    function automatic v_t saturate(input v_ext_t x);
        if (x > V_MAX_EXT) begin
            return V_MAX;
        end else if (x < V_MIN_EXT) begin
            return V_MIN;
        end else begin
            return x[V_W-1:0];
        end
    endfunction

endpackage

// File: rtl/lif_leak_sat.sv
// Leak, integrate and saturate: n = sat(v - (v >>> LEAK_SHIFT) + sum).
module lif_leak_sat
    import snn_pkg::*;
#(
    parameter int LEAK_SHIFT = 4
) (
    input  logic signed [V_W-1:0]   v,
    input  logic signed [SUM_W-1:0] sum,
    output logic signed [V_W-1:0]   n
);

    v_ext_t v_ext;
    v_ext_t s_ext;
    v_ext_t leaked;
    v_ext_t total;

    // Two guard bits cover the full swing of v plus the largest sum without wrapping.
    assign v_ext  = {{2{v[V_W-1]}}, v};
    assign s_ext  = {{(V_W+2-SUM_W){sum[SUM_W-1]}}, sum};
    assign leaked = v_ext - (v_ext >>> LEAK_SHIFT);
    assign total  = leaked + s_ext;
    assign n      = saturate(total);

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates one MAC sum per timestep, fires, then idles refractory.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int LEAK_SHIFT  = 4,
    parameter int REFRACT_LEN = 2,
    parameter logic signed [V_W-1:0] V_REST = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sum_valid,
    input  logic signed [SUM_W-1:0] sum_in,
    input  logic signed [V_W-1:0]   threshold,
    input  logic                    clear,
    output logic                    spike_out,
    output logic signed [V_W-1:0]   v_mem,
    output logic                    v_valid,
    output logic                    refractory
);

    localparam int CNT_W = (REFRACT_LEN > 0) ? $clog2(REFRACT_LEN + 1) : 1;

    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    v_t               v_next;

    lif_leak_sat #(
        .LEAK_SHIFT(LEAK_SHIFT)
    ) u_leak_sat (
        .v  (v_mem),
        .sum(sum_in),
        .n  (v_next)
    );

    // NOTE: every register here uses <= so all updates see pre-edge values; rst is in the
    // sensitivity list, making it take effect immediately rather than at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INTEGRATE;
            count     <= '0;
            v_mem     <= V_REST;
            spike_out <= 1'b0;
            v_valid   <= 1'b0;
        end else if (clear) begin
            state     <= INTEGRATE;
            count     <= '0;
            v_mem     <= V_REST;
            spike_out <= 1'b0;
            v_valid   <= 1'b0;
        end else if (sum_valid) begin
            v_valid <= 1'b1;
            if (state == INTEGRATE) begin
                if (v_next >= threshold) begin
                    spike_out <= 1'b1;
                    v_mem     <= V_REST;
                    if (REFRACT_LEN > 0) begin
                        state <= REFRACT;
                        count <= CNT_W'(REFRACT_LEN);
                    end
                end else begin
                    spike_out <= 1'b0;
                    v_mem     <= v_next;
                end
            end else begin
                // Refractory timesteps discard the sum and hold rest without leaking.
                spike_out <= 1'b0;
                v_mem     <= V_REST;
                count     <= count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state <= INTEGRATE;
                end
            end
        end else begin
            spike_out <= 1'b0;
            v_valid   <= 1'b0;
        end
    end

    assign refractory = (state == REFRACT);

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: directed vector table, multi-cycle corners, random vs model.
module tb_lif_neuron;
    import snn_pkg::*;

    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst;
    logic sum_valid;
    logic clear;
    logic signed [SUM_W-1:0] sum_in;
    logic signed [V_W-1:0]   threshold;

    logic                  spike_a, valid_a, refr_a;
    logic signed [V_W-1:0] v_mem_a;
    logic                  spike_b, valid_b, refr_b;
    logic signed [V_W-1:0] v_mem_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lif_neuron #(.LEAK_SHIFT(4), .REFRACT_LEN(RL), .V_REST('0)) dut_a (
        .clk(clk), .rst(rst), .sum_valid(sum_valid), .sum_in(sum_in),
        .threshold(threshold), .clear(clear), .spike_out(spike_a),
        .v_mem(v_mem_a), .v_valid(valid_a), .refractory(refr_a)
    );

    lif_neuron #(.LEAK_SHIFT(8), .REFRACT_LEN(RL), .V_REST('0)) dut_b (
        .clk(clk), .rst(rst), .sum_valid(sum_valid), .sum_in(sum_in),
        .threshold(threshold), .clear(clear), .spike_out(spike_b),
        .v_mem(v_mem_b), .v_valid(valid_b), .refractory(refr_b)
    );

    typedef struct {
        int v;
        int cnt;
        bit refr;
        bit spike;
        bit valid;
    } model_t;

    model_t m_a, m_b;

    function automatic model_t model_reset();
        model_t r;
        r.v = 0; r.cnt = 0; r.refr = 0; r.spike = 0; r.valid = 0;
        return r;
    endfunction

    // Behavioural neuron: floor-division leak, clamp to 16-bit range, fire/refract rules.
    function automatic model_t model_step(model_t m, bit sv, bit clr, int s, int thr, int shift);
        model_t r = m;
        int d, lk, n;
        if (clr) begin
            r = model_reset();
        end else if (sv) begin
            r.valid = 1;
            r.spike = 0;
            if (!m.refr) begin
                d  = 1 << shift;
                lk = (m.v >= 0) ? m.v / d : -((-m.v + d - 1) / d);
                n  = m.v - lk + s;
                if (n > 32767) n = 32767;
                if (n < -32768) n = -32768;
                if (n >= thr) begin
                    r.spike = 1;
                    r.v     = 0;
                    r.refr  = (RL > 0);
                    r.cnt   = RL;
                end else begin
                    r.v = n;
                end
            end else begin
                r.v   = 0;
                r.cnt = m.cnt - 1;
                if (r.cnt == 0) r.refr = 0;
            end
        end else begin
            r.spike = 0;
            r.valid = 0;
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_models();
        check("model_a_v",     int'(v_mem_a), m_a.v);
        check("model_a_spike", int'(spike_a), int'(m_a.spike));
        check("model_a_valid", int'(valid_a), int'(m_a.valid));
        check("model_a_refr",  int'(refr_a),  int'(m_a.refr));
        check("model_b_v",     int'(v_mem_b), m_b.v);
        check("model_b_spike", int'(spike_b), int'(m_b.spike));
        check("model_b_valid", int'(valid_b), int'(m_b.valid));
        check("model_b_refr",  int'(refr_b),  int'(m_b.refr));
    endtask

    // Drive one cycle of inputs, advance past the edge, update models and compare.
    task automatic step(input bit sv, input bit clr, input int s, input int thr);
        sum_valid = sv;
        clear     = clr;
        sum_in    = SUM_W'(s);
        threshold = V_W'(thr);
        @(posedge clk);
        #1;
        m_a = model_step(m_a, sv, clr, s, thr, 4);
        m_b = model_step(m_b, sv, clr, s, thr, 8);
        compare_models();
        sum_valid = 1'b0;
        clear     = 1'b0;
    endtask

    typedef struct {
        bit sv;
        bit clr;
        int s;
        int thr;
        int v;
        bit sp;
        bit vl;
        bit rf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int  prev;
        int  pre_sat;
        bit  fired;
        bit  sv;
        bit  clr;
        int  s;
        int  thr;

        rst = 1'b1; sum_valid = 1'b0; clear = 1'b0; sum_in = '0; threshold = '0;
        m_a = model_reset();
        m_b = model_reset();
        #2;
        check("reset_v",     int'(v_mem_a), 0);
        check("reset_spike", int'(spike_a), 0);
        check("reset_valid", int'(valid_a), 0);
        check("reset_refr",  int'(refr_a),  0);
        #1 rst = 1'b0;

        // Neuron A (LEAK_SHIFT=4): fire after three 64s, refractory for two pulses, clear, resume.
        vecs[0] = '{1, 0,  64, 128,  64, 0, 1, 0};
        vecs[1] = '{1, 0,  64, 128, 124, 0, 1, 0};
        vecs[2] = '{1, 0,  64, 128,   0, 1, 1, 1};
        vecs[3] = '{0, 0,   0, 128,   0, 0, 0, 1};
        vecs[4] = '{1, 0, 200, 128,   0, 0, 1, 1};
        vecs[5] = '{1, 0, 200, 128,   0, 0, 1, 0};
        vecs[6] = '{1, 0, 200, 128,   0, 1, 1, 1};
        vecs[7] = '{1, 1, 100, 128,   0, 0, 0, 0};
        vecs[8] = '{1, 0,  50, 128,  50, 0, 1, 0};
        vecs[9] = '{0, 0,  77, 128,  50, 0, 0, 0};

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].sv, vecs[i].clr, vecs[i].s, vecs[i].thr);
            check($sformatf("vec%0d_v", i),     int'(v_mem_a), vecs[i].v);
            check($sformatf("vec%0d_spike", i), int'(spike_a), int'(vecs[i].sp));
            check($sformatf("vec%0d_valid", i), int'(valid_a), int'(vecs[i].vl));
            check($sformatf("vec%0d_refr", i),  int'(refr_a),  int'(vecs[i].rf));
        end

        // Fire A (50 - 3 + 200 = 247), then reset asynchronously mid-cycle while refractory.
        step(1, 0, 200, 128);
        check("pre_rst_spike", int'(spike_a), 1);
        check("pre_rst_refr",  int'(refr_a),  1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_v",     int'(v_mem_a), 0);
        check("async_rst_spike", int'(spike_a), 0);
        check("async_rst_valid", int'(valid_a), 0);
        check("async_rst_refr",  int'(refr_a),  0);
        check("async_rst_b_v",   int'(v_mem_b), 0);
        #3 rst = 1'b0;
        m_a = model_reset();
        m_b = model_reset();

        // Neuron B (LEAK_SHIFT=8): negative saturation must clamp, never wrap, never fire.
        step(0, 1, 0, 128);
        for (int i = 0; i < 40; i++) begin
            step(1, 0, -1024, 128);
            check("neg_no_wrap",  int'(v_mem_b <= 0), 1);
            check("neg_no_spike", int'(spike_b), 0);
        end
        check("neg_clamped", int'(v_mem_b), -32768);

        // Neuron B: positive clamp fires exactly when the saturated value reaches 32767.
        step(0, 1, 0, 32767);
        fired = 0;
        for (int i = 0; i < 80; i++) begin
            prev = int'(v_mem_b);
            step(1, 0, 1023, 32767);
            if (spike_b) begin
                fired   = 1;
                pre_sat = prev - (prev / 256) + 1023;
                check("pos_fire_v",   int'(v_mem_b), 0);
                check("pos_fire_sat", int'(pre_sat >= 32767), 1);
                break;
            end
            check("pos_monotonic", int'(int'(v_mem_b) > prev), 1);
        end
        check("pos_fired_in_budget", int'(fired), 1);
        step(0, 0, 0, 32767);
        check("pos_no_double_spike", int'(spike_b), 0);

        // Random traffic on both neurons against the behavioural model.
        for (int i = 0; i < 400; i++) begin
            sv  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            s   = int'($urandom_range(0, 2047)) - 1024;
            if ($urandom_range(0, 7) == 0) begin
                thr = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                thr = int'($urandom_range(0, 3000)) - 500;
            end
            step(sv, clr, s, thr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
